biquad_mac_pipeline: RTL

Multi-channel, time-multiplexed Direct Form I biquad IIR. One shared signed multiplier/accumulator serves NUM_CH channels, each with its own history and double-buffered coefficient bank. Samples enter and leave through valid/ready handshakes. It sits between the sample source and the output DAC/serialiser in the audio path and replaces the single-channel combinational filter.

---
 rtl/biquad_mac_pipeline_if.sv | 26 ++
 rtl/biquad_mac_pipeline.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/biquad_mac_pipeline_if.sv
// Sample stream bundle for the biquad block: input handshake plus output handshake.
// Both directions use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface biquad_mac_pipeline_if #(
  parameter int DATA_W = 24,
  parameter int CH_W   = 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_sample;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic signed [DATA_W-1:0] sample_out;
  logic                     sat_flag;

  modport master (
    output in_valid, in_ch, in_sample, out_ready,
    input  in_ready, out_valid, out_ch, sample_out, sat_flag
  );

  modport slave (
    input  in_valid, in_ch, in_sample, out_ready,
    output in_ready, out_valid, out_ch, sample_out, sat_flag
  );
endinterface

// File: rtl/biquad_mac_pipeline.sv
// Time-multiplexed multi-channel Direct Form I biquad; one shared multiplier walks
// the five taps of the latched channel, then rounds, saturates and hands the result out.
module biquad_mac_pipeline #(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 24,
  parameter int FRAC_BITS = 16,
  parameter int NUM_CH    = 2,
  parameter int ACC_W     = DATA_W + COEF_W + 4,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     sample_clock,
  input  logic                     reset_n,
  biquad_mac_pipeline_if.slave     stream,
  input  logic                     coef_we,
  input  logic [CH_W-1:0]          coef_ch,
  input  logic [2:0]               coef_sel,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_commit,
  input  logic                     hist_clr,
  output logic [1:0]               state_dbg
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic signed [COEF_W-1:0] UNITY = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic signed [ACC_W-1:0]  ROUND_K = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t                   state;
  logic [2:0]               mac_step;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x_lat;
  logic [CH_W-1:0]          ch_lat;
  logic                     commit_pending;
  logic                     clr_pending;

  // Coefficient order within a bank: b0, b1, b2, a1, a2.
  logic signed [COEF_W-1:0] act_coef [NUM_CH][5];
  logic signed [COEF_W-1:0] shd_coef [NUM_CH][5];
  logic signed [DATA_W-1:0] x1_h [NUM_CH];
  logic signed [DATA_W-1:0] x2_h [NUM_CH];
  logic signed [DATA_W-1:0] y1_h [NUM_CH];
  logic signed [DATA_W-1:0] y2_h [NUM_CH];

  logic signed [COEF_W-1:0] coef_op;
  logic signed [DATA_W-1:0] data_op;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  rnd_shift;
  logic signed [DATA_W-1:0] sat_val;
  logic                     sat_now;

  assign state_dbg = state;

  always_comb begin
    coef_op = '0;
    data_op = '0;
    case (mac_step)
      3'd0: begin coef_op = act_coef[ch_lat][0]; data_op = x_lat;        end
      3'd1: begin coef_op = act_coef[ch_lat][1]; data_op = x1_h[ch_lat]; end
      3'd2: begin coef_op = act_coef[ch_lat][2]; data_op = x2_h[ch_lat]; end
      3'd3: begin coef_op = act_coef[ch_lat][3]; data_op = y1_h[ch_lat]; end
      3'd4: begin coef_op = act_coef[ch_lat][4]; data_op = y2_h[ch_lat]; end
      default: begin coef_op = '0; data_op = '0; end
    endcase
  end

  assign prod     = coef_op * data_op;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_comb begin
    rnd_sum   = acc + ROUND_K;
    rnd_shift = rnd_sum >>> FRAC_BITS;
    sat_now   = 1'b0;
    sat_val   = rnd_shift[DATA_W-1:0];
    if (rnd_shift > SAT_MAX) begin
      sat_now = 1'b1;
      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (rnd_shift < SAT_MIN) begin
      sat_now = 1'b1;
      sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  // Shadow banks take writes in any state; selectors 5..7 and absent channels are dropped.
  always_ff @(posedge sample_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 5; k++) begin
          shd_coef[c][k] <= (k == 0) ? UNITY : '0;
        end
      end
    end else if (coef_we && (coef_sel <= 3'd4) && ({1'b0, coef_ch} < NUM_CH_L)) begin
      shd_coef[coef_ch][coef_sel] <= coef_data;
    end
  end

  always_ff @(posedge sample_clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      stream.in_ready   <= 1'b1;
      stream.out_valid  <= 1'b0;
      stream.sample_out <= '0;
      stream.out_ch     <= '0;
      stream.sat_flag   <= 1'b0;
      mac_step          <= '0;
      acc               <= '0;
      x_lat             <= '0;
      ch_lat            <= '0;
      commit_pending    <= 1'b0;
      clr_pending       <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 5; k++) begin
          act_coef[c][k] <= (k == 0) ? UNITY : '0;
        end
        x1_h[c] <= '0;
        x2_h[c] <= '0;
        y1_h[c] <= '0;
        y2_h[c] <= '0;
      end
    end else begin
      // Outside IDLE, commit/clear requests are remembered; the OUT branch below overrides on exit.
      if (state != IDLE) begin
        if (coef_commit) commit_pending <= 1'b1;
        if (hist_clr)    clr_pending    <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (coef_commit) act_coef <= shd_coef;
          if (hist_clr) begin
            for (int c = 0; c < NUM_CH; c++) begin
              x1_h[c] <= '0;
              x2_h[c] <= '0;
              y1_h[c] <= '0;
              y2_h[c] <= '0;
            end
          end
          if (stream.in_valid && stream.in_ready) begin
            x_lat           <= stream.in_sample;
            ch_lat          <= ({1'b0, stream.in_ch} < NUM_CH_L) ? stream.in_ch : '0;
            acc             <= '0;
            mac_step        <= '0;
            stream.in_ready <= 1'b0;
            state           <= MAC;
          end
        end
        MAC: begin
          acc <= (mac_step >= 3'd3) ? acc - prod_ext : acc + prod_ext;
          if (mac_step == 3'd4) begin
            mac_step <= '0;
            state    <= ROUND;
          end else begin
            mac_step <= mac_step + 3'd1;
          end
        end
        ROUND: begin
          stream.sample_out <= sat_val;
          stream.sat_flag   <= sat_now;
          stream.out_ch     <= ch_lat;
          stream.out_valid  <= 1'b1;
          x2_h[ch_lat]      <= x1_h[ch_lat];
          x1_h[ch_lat]      <= x_lat;
          y2_h[ch_lat]      <= y1_h[ch_lat];
          y1_h[ch_lat]      <= sat_val;
          state             <= OUT;
        end
        OUT: begin
          if (stream.out_ready) begin
            stream.out_valid <= 1'b0;
            stream.in_ready  <= 1'b1;
            state            <= IDLE;
            if (commit_pending || coef_commit) act_coef <= shd_coef;
            if (clr_pending || hist_clr) begin
              for (int c = 0; c < NUM_CH; c++) begin
                x1_h[c] <= '0;
                x2_h[c] <= '0;
                y1_h[c] <= '0;
                y2_h[c] <= '0;
              end
            end
            commit_pending <= 1'b0;
            clr_pending    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
